// File: rtl/sata_fis_mux_if.sv
// -----------------------------------------------------------------------------
// sata_fis_mux_if
//
// Signal bundle for the 2:1 SATA FIS multiplexer. Both source streams and the
// merged output stream live in one interface so the mux takes a single port.
//
// Signals
//   i1_dat/val/eop/err  source #1 word, valid, last word of frame, error flag
//   i1_rdy              source #1 word accepted when i1_val & i1_rdy
//   i2_*                same set for source #2
//   o_dat/val/eop/err   merged stream, registered inside the mux
//   o_src               origin of the word on o_*: 0 = #1, 1 = #2
//   o_rdy               downstream ready
//
// Modports
//   slave   the multiplexer itself
//   master  the surroundings: the two sources plus the downstream sink
// -----------------------------------------------------------------------------
interface sata_fis_mux_if;

  logic [31:0] i1_dat;
  logic        i1_val;
  logic        i1_eop;
  logic        i1_err;
  logic        i1_rdy;

  logic [31:0] i2_dat;
  logic        i2_val;
  logic        i2_eop;
  logic        i2_err;
  logic        i2_rdy;

  logic [31:0] o_dat;
  logic        o_val;
  logic        o_eop;
  logic        o_err;
  logic        o_src;
  logic        o_rdy;

  modport slave (
    input  i1_dat, i1_val, i1_eop, i1_err,
    output i1_rdy,
    input  i2_dat, i2_val, i2_eop, i2_err,
    output i2_rdy,
    output o_dat, o_val, o_eop, o_err, o_src,
    input  o_rdy
  );

  modport master (
    output i1_dat, i1_val, i1_eop, i1_err,
    input  i1_rdy,
    output i2_dat, i2_val, i2_eop, i2_err,
    input  i2_rdy,
    input  o_dat, o_val, o_eop, o_err, o_src,
    output o_rdy
  );

endinterface

// File: rtl/sata_fis_mux.sv
// -----------------------------------------------------------------------------
// sata_fis_mux
//
// Frame-aware 2:1 multiplexer for SATA FIS streams (transmit-side counterpart
// of the FIS demultiplexer). Two independent sources are merged into one
// registered output stream. Arbitration only happens at frame boundaries:
// once the first word of a multi-word frame is accepted, the owning source
// keeps the grant until its eop word is accepted, so frames never interleave.
//
// Parameters
//   RR       1 = round-robin between the sources, 0 = fixed priority (#1 wins)
//
// Ports
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset
//   fis      sata_fis_mux_if.slave bundle (both sources + merged output)
//
// Timing
//   One register stage: a word accepted at edge k is on o_* after edge k.
//   o_rdy reaches i1_rdy/i2_rdy combinationally; iN_val never reaches o_*.
// -----------------------------------------------------------------------------
module sata_fis_mux #(
  parameter bit RR = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  sata_fis_mux_if.slave  fis
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK1 = 2'd1,
    LOCK2 = 2'd2
  } lock_t;

  lock_t lock_q;
  lock_t lock_d;

  // Source that won the most recent frame, encoded like o_src (0 = #1,
  // 1 = #2). Resetting it to "#2 was last" makes #1 win the first contention.
  logic last_q;
  logic last_d;

  logic grant1;
  logic grant2;
  logic load_en;
  logic rdy1;
  logic rdy2;
  logic acc1;
  logic acc2;

  logic [31:0] dat_q;
  logic        val_q;
  logic        eop_q;
  logic        err_q;
  logic        src_q;

  // The stage can take a new word when it is empty or being drained this cycle.
  assign load_en = ~val_q | fis.o_rdy;

  assign acc1 = fis.i1_val & rdy1;
  assign acc2 = fis.i2_val & rdy2;

  // Lock state and round-robin history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= IDLE;
      last_q <= 1'b1;
    end else begin
      lock_q <= lock_d;
      last_q <= last_d;
    end
  end

  // Next-state: enter a lock on the first word of a multi-word frame, leave it
  // on the accepted eop word. Single-word frames never leave IDLE, but they
  // still count as a win for the round-robin history. err does not end a frame.
  always_comb begin
    lock_d = lock_q;
    last_d = last_q;
    case (lock_q)
      IDLE: begin
        if (acc1) begin
          last_d = 1'b0;
          if (!fis.i1_eop) lock_d = LOCK1;
        end else if (acc2) begin
          last_d = 1'b1;
          if (!fis.i2_eop) lock_d = LOCK2;
        end
      end
      LOCK1: begin
        if (acc1 && fis.i1_eop) lock_d = IDLE;
      end
      LOCK2: begin
        if (acc2 && fis.i2_eop) lock_d = IDLE;
      end
      default: lock_d = IDLE;
    endcase
  end

  // Grant decode. In IDLE the grant follows the valids in the same cycle;
  // inside a lock the owner is granted regardless of the other source.
  // Ready is additionally gated by reset_n so no source sees a handshake while
  // the block is held in reset.
  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    case (lock_q)
      IDLE: begin
        if (fis.i1_val && fis.i2_val) begin
          if (RR) begin
            grant1 = last_q;
            grant2 = ~last_q;
          end else begin
            grant1 = 1'b1;
          end
        end else begin
          grant1 = fis.i1_val;
          grant2 = fis.i2_val;
        end
      end
      LOCK1:   grant1 = 1'b1;
      LOCK2:   grant2 = 1'b1;
      default: begin
        grant1 = 1'b0;
        grant2 = 1'b0;
      end
    endcase
    rdy1 = grant1 & load_en & reset_n;
    rdy2 = grant2 & load_en & reset_n;
  end

  // Output register. At most one source is granted, so acc1 and acc2 are
  // never both set; the priority here only keeps the structure simple.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dat_q <= 32'd0;
      val_q <= 1'b0;
      eop_q <= 1'b0;
      err_q <= 1'b0;
      src_q <= 1'b0;
    end else if (acc1) begin
      dat_q <= fis.i1_dat;
      val_q <= 1'b1;
      eop_q <= fis.i1_eop;
      err_q <= fis.i1_err;
      src_q <= 1'b0;
    end else if (acc2) begin
      dat_q <= fis.i2_dat;
      val_q <= 1'b1;
      eop_q <= fis.i2_eop;
      err_q <= fis.i2_err;
      src_q <= 1'b1;
    end else if (fis.o_rdy) begin
      val_q <= 1'b0;
    end
  end

  assign fis.i1_rdy = rdy1;
  assign fis.i2_rdy = rdy2;
  assign fis.o_dat  = dat_q;
  assign fis.o_val  = val_q;
  assign fis.o_eop  = eop_q;
  assign fis.o_err  = err_q;
  assign fis.o_src  = src_q;

endmodule

// File: doc/sata_fis_mux.md
# sata_fis_mux

Frame-aware 2:1 multiplexer for SATA FIS streaming interfaces. It merges two independent FIS sources into one output stream. The block is the transmit-side counterpart of the FIS demultiplexer, for example link-layer TX shared between the command path and the data path. Arbitration happens only at frame boundaries, so a frame granted to one source passes contiguously, start to `eop`, with no interleaving. The output is registered, giving one pipeline stage.

## Interface
- `RR`, default 1: arbitration mode. 1 = round-robin between sources. 0 = fixed priority, source #1 wins.
- `clk` input 1: clock. All logic is on the rising edge.
- `reset_n` input 1: asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
- `i1_dat` input 32: source #1 FIS data word.
- `i1_val` input 1: source #1 word valid.
- `i1_eop` input 1: source #1 last word of frame.
- `i1_err` input 1: source #1 frame error flag, qualified by `i1_val`.
- `i1_rdy` output 1: source #1 word accepted when `i1_val & i1_rdy`.
- `i2_dat`, `i2_val`, `i2_eop`, `i2_err`, `i2_rdy`: same as above for source #2.
- `o_dat` output 32: merged data, registered.
- `o_val` output 1: merged word valid, registered.
- `o_eop` output 1: merged end of frame, registered.
- `o_err` output 1: merged error flag, registered.
- `o_src` output 1: source of the word currently on the output. 0 = #1, 1 = #2.
- `o_rdy` input 1: downstream ready.

## Operation
- Output stage: a single register holding `dat`/`eop`/`err`/`src`/`val`. Stage "can load" is `load_en = ~o_val | o_rdy`.
- State machine `lock`: IDLE, LOCK1, LOCK2.
  - IDLE is the frame boundary. Grant is computed combinationally from `i1_val`, `i2_val`, `RR` and `last_reg`.
  - When only one source is valid, that source is granted.
  - When both are valid and RR=1, the source ≠ `last_reg` is granted.
  - When both are valid and RR=0, #1 is granted.
  - When no source is valid, there is no grant.
- LOCKn: source n is granted unconditionally, whatever the other source's `val`.
- `iN_rdy = grantN & load_en`. The non-granted source always sees `rdy=0`.
- On an accepted beat from source n, the stage loads `iN_dat/eop/err`, `o_src=n-1`, `o_val=1`.
- If no beat is accepted and `o_rdy=1`, `o_val` clears.
- Transitions:
  - IDLE→LOCKn when the first beat of source n is accepted with `eop=0`.
  - LOCKn→IDLE when a beat with `eop=1` is accepted from n.
  - A single-word frame, where the first beat has `eop=1`, stays in IDLE.
- `last_reg` updates to n on acceptance of the first beat of every frame from n, including single-word frames.
- An `err` word is forwarded as data. Frame termination is by `eop` only; `err` does not release the lock.
- Reset:
  - `o_val=0`, `o_dat=0`, `o_eop=0`, `o_err=0`, `o_src=0`.
  - `lock=IDLE`, `last_reg=1`, so #1 wins the first contention.
  - `i1_rdy=i2_rdy=0` while `reset_n=0`.
- Reset mid-frame discards the lock and any word held in the stage. The truncated frame is not completed; upstream must restart.

## Timing
- Latency: an input word accepted at edge k appears on `o_*` after edge k. Latency is 1 cycle.
- Throughput: 1 word/cycle while `o_rdy=1` and the granted source streams. No bubble at frame boundaries: the last beat of frame A and the first beat of frame B from either source are accepted on consecutive cycles.
- Combinational path: `o_rdy` → `iN_rdy`. There is no path from `iN_val` to `o_*`.
- Backpressure: with `o_val=1` and `o_rdy=0`, `o_*` holds stable and both `iN_rdy` are 0.
- Grant evaluated in IDLE is instantaneous in the same cycle. A source's `val` must stay asserted until it is accepted (standard valid/ready). No source may retract `val` once asserted.

## Test plan
- Single source:
  - Stimulus: #1 sends a 4-word frame 0x11..0x14 with `o_rdy=1`, #2 idle.
  - Required: `o_*` shows 0x11..0x14 on 4 consecutive cycles, one cycle late; `o_eop` on 0x14; `o_src=0`.
- Contention, RR=1:
  - Stimulus: both sources hold 3-word frames from cycle 0 after reset.
  - Required: the #1 frame is output whole, then the #2 frame, with no gap; `o_src` = 0,0,0,1,1,1; `i2_rdy=0` during the #1 frame.
- Lock:
  - Stimulus: #2 starts a 5-word frame; #1 raises `val` at word 2.
  - Required: #1 is stalled (`i1_rdy=0`) until after #2's `eop` is accepted, then #1 is granted the next cycle.
- Fixed priority, RR=0:
  - Stimulus: both sources continuously present 1-word frames.
  - Required: only #1 is ever granted; `o_src` stays 0.
- Backpressure:
  - Stimulus: `o_rdy` toggles 1,0,0,1 mid-frame.
  - Required: `o_dat` is stable while `o_rdy=0`; no word is lost or duplicated; `iN_rdy=0` in the stall cycles.
- Reset mid-frame:
  - Stimulus: `reset_n` pulled low after word 2 of a #1 frame.
  - Required: `o_val=0` immediately (asynchronous); after release, state is IDLE; a new #2 frame is granted normally.
